// File: rtl/image_capture_writer.sv
// image_capture_writer
// Captures one IMAGE_WIDTH x IMAGE_HEIGHT frame of 8-bit pixels from a pixel
// stream, packs 64 pixels per 512-bit word (pixel k of a word in bits
// [8k+7:8k]) and writes the frame contiguously to DRAM with single-beat writes.
// Optional build macro: IMAGE_CAPTURE_GRAY_CONVERT_EN -- when defined, each
// pixel byte is the luma approximation (R + 2G + B) >> 2 through one extra
// pipeline register; when undefined the byte is pixel_rgb[7:0] with no delay.
module image_capture_writer #(
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int IMAGE_WIDTH     = 100,
  parameter int IMAGE_HEIGHT    = 100,
  parameter int WORD_FIFO_DEPTH = 16
) (
  input  logic                       clk_pixel,
  input  logic                       image_receiver_reset,
  input  logic                       image_receiver_arm,
  input  logic [DRAM_ADDR_WIDTH-1:0] image_receiver_base_addr,
  input  logic                       pixel_sof,
  input  logic                       pixel_valid,
  input  logic [23:0]                pixel_rgb,
  output logic                       image_receiver_busy,
  output logic                       image_receiver_done,
  output logic                       image_receiver_overflow,
  output logic [DRAM_ADDR_WIDTH-1:0] dram_write_addr,
  output logic [7:0]                 dram_write_len,
  output logic                       dram_write_en,
  output logic [DRAM_DATA_WIDTH-1:0] dram_write_data,
  input  logic                       dram_write_busy
);

  localparam int BYTES   = DRAM_DATA_WIDTH / 8;
  localparam int BIDX_W  = $clog2(BYTES);
  localparam int TOTAL   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int FIFO_AW = $clog2(WORD_FIFO_DEPTH);

  localparam logic [CNT_W-1:0]           LAST_PIX = CNT_W'(TOTAL - 1);
  localparam logic [BIDX_W-1:0]          LAST_LANE = BIDX_W'(BYTES - 1);
  localparam logic [DRAM_ADDR_WIDTH-1:0] ADDR_STEP = DRAM_ADDR_WIDTH'(BYTES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                     state_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       overflow_q;
  logic [CNT_W-1:0]           pix_cnt_q;
  logic [BIDX_W-1:0]          byte_idx_q;
  logic [DRAM_DATA_WIDTH-1:0] pack_q;
  logic [DRAM_DATA_WIDTH-1:0] pack_d;

  logic                       px_valid_s;
  logic                       px_sof_s;
  logic [7:0]                 px_byte_s;

  logic                       accept_s;
  logic                       last_s;
  logic                       push_s;
  logic                       push_ok_s;
  logic                       drop_s;
  logic                       arm_ok_s;

  logic [DRAM_DATA_WIDTH-1:0] fifo_mem_q [WORD_FIFO_DEPTH];
  logic [FIFO_AW:0]           wr_ptr_q;
  logic [FIFO_AW:0]           rd_ptr_q;
  logic                       fifo_empty_s;
  logic                       fifo_full_s;
  logic                       issue_s;

  logic                       wr_en_q;
  logic [DRAM_ADDR_WIDTH-1:0] wr_addr_q;
  logic [DRAM_DATA_WIDTH-1:0] wr_data_q;
  logic [DRAM_ADDR_WIDTH-1:0] wr_ptr_addr_q;

`ifdef IMAGE_CAPTURE_GRAY_CONVERT_EN
  logic [9:0] gray_sum_s;
  logic       px_valid_q;
  logic       px_sof_q;
  logic [7:0] px_byte_q;
  logic [1:0] unused_gray_lsb_s;

  // Luma approximation R + 2G + B in 10 bits; the shift by 2 drops the LSBs.
  always_comb begin
    gray_sum_s = {2'b00, pixel_rgb[23:16]} + {1'b0, pixel_rgb[15:8], 1'b0}
               + {2'b00, pixel_rgb[7:0]};
  end

  assign unused_gray_lsb_s = gray_sum_s[1:0];

  // Pipeline stage for the converted byte, with valid/sof delayed alongside.
  always_ff @(posedge clk_pixel) begin
    if (image_receiver_reset) begin
      px_valid_q <= 1'b0;
      px_sof_q   <= 1'b0;
      px_byte_q  <= 8'd0;
    end else begin
      px_valid_q <= pixel_valid;
      px_sof_q   <= pixel_sof;
      px_byte_q  <= gray_sum_s[9:2];
    end
  end

  assign px_valid_s = px_valid_q;
  assign px_sof_s   = px_sof_q;
  assign px_byte_s  = px_byte_q;
`else
  logic [15:0] unused_rgb_hi_s;

  assign unused_rgb_hi_s = pixel_rgb[23:8];
  assign px_valid_s      = pixel_valid;
  assign px_sof_s        = pixel_sof;
  assign px_byte_s       = pixel_rgb[7:0];
`endif

  // FIFO status; the extra pointer bit separates full from empty.
  always_comb begin
    fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    fifo_full_s  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    // Hold off one cycle after each request so a busy response can land.
    issue_s      = !fifo_empty_s && !dram_write_busy && !wr_en_q;
  end

  // Pixel acceptance, lane insertion and word push decisions.
  always_comb begin
    arm_ok_s = image_receiver_arm &&
               ((state_q == ST_IDLE) || (state_q == ST_DONE));
    if (px_valid_s) begin
      if (state_q == ST_CAPTURE) begin
        accept_s = 1'b1;
      end else if ((state_q == ST_ARMED) && px_sof_s) begin
        accept_s = 1'b1;
      end else begin
        accept_s = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
    end
    last_s = accept_s && (pix_cnt_q == LAST_PIX);
    pack_d = pack_q;
    pack_d[{byte_idx_q, 3'b000} +: 8] = px_byte_s;
    // A word is complete at lane 63, or early when the frame's last pixel lands.
    push_s    = accept_s && ((byte_idx_q == LAST_LANE) || last_s);
    // When full, a simultaneous pop frees the slot for this push.
    push_ok_s = push_s && (!fifo_full_s || issue_s);
    drop_s    = push_s && fifo_full_s && !issue_s;
  end

  // Capture FSM with counters, pack register and status outputs.
  always_ff @(posedge clk_pixel) begin
    if (image_receiver_reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      pix_cnt_q  <= {CNT_W{1'b0}};
      byte_idx_q <= {BIDX_W{1'b0}};
      pack_q     <= {DRAM_DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_ok_s) begin
            state_q    <= ST_ARMED;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            pix_cnt_q  <= {CNT_W{1'b0}};
            byte_idx_q <= {BIDX_W{1'b0}};
            pack_q     <= {DRAM_DATA_WIDTH{1'b0}};
          end else begin
            state_q <= state_q;
          end
        end
        ST_ARMED, ST_CAPTURE: begin
          if (accept_s) begin
            pix_cnt_q  <= pix_cnt_q + CNT_W'(1);
            byte_idx_q <= byte_idx_q + BIDX_W'(1);
            // Clearing after a push keeps the unused bytes of a partial word zero.
            pack_q     <= push_s ? {DRAM_DATA_WIDTH{1'b0}} : pack_d;
            if (last_s) begin
              state_q <= ST_FLUSH;
            end else begin
              state_q <= ST_CAPTURE;
            end
          end else begin
            state_q <= state_q;
          end
          if (drop_s) begin
            overflow_q <= 1'b1;
          end else begin
            overflow_q <= overflow_q;
          end
        end
        ST_FLUSH: begin
          if (fifo_empty_s) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= ST_FLUSH;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Word FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk_pixel) begin
    if (push_ok_s) begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= pack_d;
    end else begin
      fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]] <= fifo_mem_q[wr_ptr_q[FIFO_AW-1:0]];
    end
  end

  // Word FIFO pointers.
  always_ff @(posedge clk_pixel) begin
    if (image_receiver_reset) begin
      wr_ptr_q <= {(FIFO_AW+1){1'b0}};
      rd_ptr_q <= {(FIFO_AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_q <= wr_ptr_q + (FIFO_AW+1)'(1);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (issue_s) begin
        rd_ptr_q <= rd_ptr_q + (FIFO_AW+1)'(1);
      end else begin
        rd_ptr_q <= rd_ptr_q;
      end
    end
  end

  // DRAM request registers and the running write address.
  always_ff @(posedge clk_pixel) begin
    if (image_receiver_reset) begin
      wr_en_q       <= 1'b0;
      wr_addr_q     <= {DRAM_ADDR_WIDTH{1'b0}};
      wr_data_q     <= {DRAM_DATA_WIDTH{1'b0}};
      wr_ptr_addr_q <= {DRAM_ADDR_WIDTH{1'b0}};
    end else begin
      wr_en_q <= issue_s;
      if (issue_s) begin
        wr_addr_q <= wr_ptr_addr_q;
        wr_data_q <= fifo_mem_q[rd_ptr_q[FIFO_AW-1:0]];
      end else begin
        wr_addr_q <= wr_addr_q;
        wr_data_q <= wr_data_q;
      end
      if (arm_ok_s) begin
        wr_ptr_addr_q <= image_receiver_base_addr;
      end else if (issue_s) begin
        wr_ptr_addr_q <= wr_ptr_addr_q + ADDR_STEP;
      end else begin
        wr_ptr_addr_q <= wr_ptr_addr_q;
      end
    end
  end

  assign image_receiver_busy     = busy_q;
  assign image_receiver_done     = done_q;
  assign image_receiver_overflow = overflow_q;
  assign dram_write_en           = wr_en_q;
  assign dram_write_addr         = wr_addr_q;
  assign dram_write_data         = wr_data_q;
  assign dram_write_len          = 8'd0;

endmodule

// File: tb/tb_image_capture_writer.sv
// Self-checking bench for image_capture_writer: table of frame scenarios,
// scoreboard of expected DRAM writes, plus a reset-mid-frame sequence.
module tb_image_capture_writer;

  localparam int AW     = 39;
  localparam int DW     = 512;
  localparam int TOTAL  = 100 * 100;
  localparam int DEPTH  = 16;
  localparam int NWORDS = (TOTAL + 63) / 64;

  logic          clk;
  logic          rst;
  logic          arm;
  logic [AW-1:0] base;
  logic          sof;
  logic          valid;
  logic [23:0]   rgb;
  logic          busy_o;
  logic          done_o;
  logic          ovf_o;
  logic [AW-1:0] waddr;
  logic [7:0]    wlen;
  logic          wen;
  logic [DW-1:0] wdata;
  logic          wbusy;

  image_capture_writer dut (
    .clk_pixel                (clk),
    .image_receiver_reset     (rst),
    .image_receiver_arm       (arm),
    .image_receiver_base_addr (base),
    .pixel_sof                (sof),
    .pixel_valid              (valid),
    .pixel_rgb                (rgb),
    .image_receiver_busy      (busy_o),
    .image_receiver_done      (done_o),
    .image_receiver_overflow  (ovf_o),
    .dram_write_addr          (waddr),
    .dram_write_len           (wlen),
    .dram_write_en            (wen),
    .dram_write_data          (wdata),
    .dram_write_busy          (wbusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [AW-1:0] base;
    int            busy_mode;   // 0 idle, 1 held during frame, 2 toggling
    int            n_ign;       // non-sof pixels sent while armed
    bit            arm_mid;     // stray arm pulse during capture
    bit            special;     // pixel 0 carries 0x4080C0
    int            exp_writes;
    bit            exp_ovf;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[4];
  int   checks = 0;
  int   errors = 0;
  int   wr_count = 0;
  int   cyc = 0;
  int   busy_mode = 0;
  bit   hold_busy = 1'b0;
  bit   ignore_writes = 1'b0;
  logic prev_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input logic [23:0] c);
`ifdef IMAGE_CAPTURE_GRAY_CONVERT_EN
    logic [9:0] s;
    s = {2'b00, c[23:16]} + {1'b0, c[15:8], 1'b0} + {2'b00, c[7:0]};
    return s[9:2];
`else
    return c[7:0];
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (busy_mode)
      1:       wbusy = hold_busy;
      2:       wbusy = ((cyc / 3) % 2) == 1;
      default: wbusy = 1'b0;
    endcase
  endtask

  // Scoreboard monitor: sample on the falling edge, compare each write.
  always @(negedge clk) begin
    if (wen) begin
      wr_t e;
      wr_count++;
      checks++;
      if (prev_en) begin
        errors++;
        $display("FAIL back_to_back_en: got en in adjacent cycles at addr %0h", waddr);
      end
      if (!ignore_writes) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0h, expected no write", waddr);
        end else begin
          e = exp_q.pop_front();
          if (waddr !== e.addr || wdata !== e.data || wlen !== 8'd0) begin
            errors++;
            $display("FAIL write_word: got addr %0h len %0h data %h expected addr %0h len 0 data %h",
                     waddr, wlen, wdata, e.addr, e.data);
          end
        end
      end
    end
    prev_en = wen;
  end

  task automatic run_frame(input vec_t v);
    logic [DW-1:0] w;
    int            nb;
    int            kept;
    int            t;
    logic [7:0]    p;
    w    = '0;
    nb   = 0;
    kept = 0;
    wr_count  = 0;
    busy_mode = v.busy_mode;
    hold_busy = (v.busy_mode == 1);
    wbusy     = hold_busy;
    base = v.base;
    arm  = 1'b1;
    tick();
    arm  = 1'b0;
    base = 39'h55_5555_5540;
    chk("busy_after_arm", {63'd0, busy_o}, 64'd1);
    chk("done_cleared_by_arm", {63'd0, done_o}, 64'd0);
    chk("ovf_cleared_by_arm", {63'd0, ovf_o}, 64'd0);
    for (int i = 0; i < v.n_ign; i++) begin
      valid = 1'b1;
      sof   = 1'b0;
      rgb   = 24'hEEEEEE;
      tick();
    end
    for (int i = 0; i < TOTAL; i++) begin
      p     = i[7:0];
      rgb   = (v.special && i == 0) ? 24'h4080C0 : {p, p, p};
      valid = 1'b1;
      sof   = (i == 0);
      arm   = v.arm_mid && (i == 500);
      if (arm) base = 39'h7F_FFFF_FFC0;
      w[nb*8 +: 8] = model_byte(rgb);
      nb++;
      if (nb == 64 || i == TOTAL - 1) begin
        if (!(v.busy_mode == 1 && kept >= DEPTH)) begin
          exp_q.push_back('{addr: v.base + AW'(64 * kept), data: w});
          kept++;
        end
        w  = '0;
        nb = 0;
      end
      tick();
    end
    arm = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      sof   = 1'b1;
      rgb   = 24'h555555;
      tick();
    end
    valid = 1'b0;
    sof   = 1'b0;
    if (v.busy_mode == 1) begin
      chk("no_write_while_busy", 64'(wr_count), 64'd0);
      chk("ovf_while_busy", {63'd0, ovf_o}, 64'd1);
      chk("busy_in_flush", {63'd0, busy_o}, 64'd1);
      hold_busy = 1'b0;
    end
    t = 0;
    while (!done_o && t < 3000) begin
      tick();
      t++;
    end
    chk("done_reached", {63'd0, done_o}, 64'd1);
    tick();
    tick();
    chk("write_count", 64'(wr_count), 64'(v.exp_writes));
    chk("overflow", {63'd0, ovf_o}, {63'd0, v.exp_ovf});
    chk("busy_after_done", {63'd0, busy_o}, 64'd0);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {63'd0, busy_o}, 64'd0);
    chk({tag, "_done"}, {63'd0, done_o}, 64'd0);
    chk({tag, "_ovf"},  {63'd0, ovf_o}, 64'd0);
    chk({tag, "_en"},   {63'd0, wen}, 64'd0);
    chk({tag, "_addr"}, 64'(waddr), 64'd0);
    chk({tag, "_len"},  64'(wlen), 64'd0);
    chk({tag, "_data"}, {63'd0, (wdata == '0)}, 64'd1);
  endtask

  initial begin
    vecs[0] = '{base: 39'h1000,  busy_mode: 0, n_ign: 0, arm_mid: 1'b0, special: 1'b0,
                exp_writes: NWORDS, exp_ovf: 1'b0};
    vecs[1] = '{base: 39'h4000,  busy_mode: 0, n_ign: 5, arm_mid: 1'b0, special: 1'b0,
                exp_writes: NWORDS, exp_ovf: 1'b0};
    vecs[2] = '{base: 39'h10000, busy_mode: 1, n_ign: 0, arm_mid: 1'b0, special: 1'b0,
                exp_writes: DEPTH, exp_ovf: 1'b1};
    vecs[3] = '{base: 39'h20000, busy_mode: 2, n_ign: 0, arm_mid: 1'b1, special: 1'b1,
                exp_writes: NWORDS, exp_ovf: 1'b0};

    rst = 1'b1; arm = 1'b0; base = '0; sof = 1'b0; valid = 1'b0; rgb = '0; wbusy = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    for (int r = 0; r < 4; r++) begin
      run_frame(vecs[r]);
    end

    // Reset in the middle of a frame, after three writes went out.
    busy_mode     = 0;
    wbusy         = 1'b0;
    ignore_writes = 1'b1;
    wr_count      = 0;
    base = 39'h2000;
    arm  = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < TOTAL && wr_count < 3; i++) begin
      valid = 1'b1;
      sof   = (i == 0);
      rgb   = {3{8'h33}};
      tick();
    end
    chk("mid_frame_writes", {63'd0, (wr_count >= 3)}, 64'd1);
    rst = 1'b1;
    valid = 1'b0;
    sof = 1'b0;
    tick();
    check_reset_outputs("midreset");
    tick();
    check_reset_outputs("midreset2");
    rst = 1'b0;
    tick();
    ignore_writes = 1'b0;
    exp_q.delete();
    run_frame('{base: 39'h8000, busy_mode: 0, n_ign: 0, arm_mid: 1'b0, special: 1'b0,
                exp_writes: NWORDS, exp_ovf: 1'b0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/image_capture_writer.md
Name: image_capture_writer

Overview:
- Write-side counterpart of the DRAM-to-display image path.
- Captures one frame of IMAGE_WIDTH x IMAGE_HEIGHT 8-bit pixels from a pixel stream, for example a camera.
- Packs 64 pixels per 512-bit word and writes the frame contiguously to DRAM through the dram_write_* single-beat interface.
- Byte layout matches the display reader: pixel k of a word occupies bits [8k+7:8k].

Parameters:
- DRAM_DATA_WIDTH, 512, DRAM word width; bytes per word = DRAM_DATA_WIDTH/8 = 64.
- DRAM_ADDR_WIDTH, 39, DRAM byte address width.
- IMAGE_WIDTH, 100, pixels per line.
- IMAGE_HEIGHT, 100, lines per frame.
- WORD_FIFO_DEPTH, 16, number of packed words buffered ahead of DRAM; power of 2.

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- image_receiver_reset  in  1  synchronous, active-high reset.
- image_receiver_arm  in  1  one-cycle pulse; latches base address and arms capture.
- image_receiver_base_addr  in  DRAM_ADDR_WIDTH  frame start byte address; must be 64-byte aligned.
- pixel_sof  in  1  start of frame, qualified by pixel_valid.
- pixel_valid  in  1  pixel strobe.
- pixel_rgb  in  24  pixel data.
- image_receiver_busy  out  1  high in ARMED, CAPTURE and FLUSH.
- image_receiver_done  out  1  level; frame fully issued to DRAM.
- image_receiver_overflow  out  1  sticky; a word was dropped.
- dram_write_addr  out  DRAM_ADDR_WIDTH  write byte address.
- dram_write_len  out  8  burst length - 1; always 0.
- dram_write_en  out  1  one-cycle write request.
- dram_write_data  out  DRAM_DATA_WIDTH  write data.
- dram_write_busy  in  1  DRAM writer cannot accept a request.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE; FIFO empty; all counters 0.
  - Reset mid-operation aborts immediately.
  - A DRAM write already issued is not retracted.
- FSM states and transitions:
  - IDLE: on arm, go to ARMED.
  - ARMED: on pixel_valid & pixel_sof, go to CAPTURE.
  - CAPTURE: after the last pixel is accepted, go to FLUSH.
  - FLUSH: when the FIFO is empty and no write is pending, go to DONE.
  - DONE: on arm, go to ARMED.
- Arm pulse (in IDLE or DONE):
  - latches base_addr into the write pointer;
  - clears done, overflow and all counters.
  - An arm pulse in any other state is ignored.
- ARMED: pixels without sof are ignored. The sof pixel itself is pixel 0.
- CAPTURE:
  - Each valid pixel writes byte pixel_byte into the pack register at lane byte_idx, then byte_idx increments.
  - When byte_idx wraps 63->0, the packed word is pushed into the FIFO.
  - pixel_sof during CAPTURE is ignored; the pixel is counted as data.
  - After pixel number IMAGE_WIDTH*IMAGE_HEIGHT-1 is accepted:
    - if byte_idx is nonzero, the partial word is pushed with unused upper bytes zero;
    - the FSM then enters FLUSH.
  - Further pixels are ignored until the next arm.
- Pixel counter width is $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1).
- Push when the FIFO is full: the word is dropped, overflow is set, and the pixel count still advances, so the frame still terminates. A push and a pop in the same cycle are allowed when full.
- DRAM issue:
  - Issue when the FIFO is non-empty, ~dram_write_busy, and no issue occurred in the previous cycle. The one-cycle hold-off covers busy latency.
  - On issue: dram_write_en=1 for one cycle, dram_write_data = FIFO head, dram_write_addr = pointer, dram_write_len = 0.
  - Then pop the FIFO and advance the pointer by 64.
  - Outputs are registered: request is visible the cycle after the decision.
  - addr and data hold their last values while en is low.
- Total writes per frame = ceil(W*H/64). For the defaults that is 157 writes, with the last write holding 16 valid bytes.
- done rises the cycle after the final write is issued while in FLUSH.

Optional Feature:
- Macro IMAGE_CAPTURE_GRAY_CONVERT_EN.
- Defined: pixel_byte = (R + 2G + B) >> 2 using a 10-bit sum, where R=pixel_rgb[23:16], G=[15:8], B=[7:0]. One extra pipeline register is added on pixel path, with valid/sof delayed to match.
- Undefined: pixel_byte = pixel_rgb[7:0], with no extra latency.

Test Plan:
- Reset then arm with base 0x1000; send sof plus 10000 pixels with value = index mod 256, dram_write_busy=0.
  - Expect 157 writes at addresses 0x1000..0x3700, step 0x40.
  - Word 0 byte k = k.
  - Last word bytes 0-15 = 0x00-0x0F (pixels 9984-9999 mod 256), bytes 16-63 = 0.
  - done=1, overflow=0.
- Send 5 pixels while in ARMED without sof, then the sof frame -> the ignored pixels do not appear; first written byte = the sof pixel.
- Hold dram_write_busy=1 during a full frame -> 16 words buffered, overflow=1, no dram_write_en; after busy drops, exactly 16 writes and then done.
- Toggle dram_write_busy every 3 cycles -> no two dram_write_en in adjacent cycles; data order and addresses intact.
- Apply reset mid-frame after 3 writes, then arm with base 0x8000 and a full frame -> outputs 0 during reset; the new frame starts at 0x8000 with 157 writes.
- With IMAGE_CAPTURE_GRAY_CONVERT_EN defined, pixel_rgb=0x40_80_C0 -> byte (64+256+192)>>2 = 0x80.
